// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// General-purpose up/down event/timer counter. It replaces the fixed 8-bit
// counter without changes when WIDTH=8 and MAX_VAL=255.
//
// Count range is 0..MAX_VAL. SATURATE selects what happens at a boundary:
//   0 = wrap modulo MAX_VAL+1
//   1 = hold at the boundary
// Either way, a boundary event produces a one-cycle registered pulse on ovf
// (going up) or on unf (going down).
//
// Priority on each clock edge: rst > load > en > hold.
//
// Optional build macro: UPDOWN_CNT_STEP_EN
//   defined   : adds the step input, and each enabled cycle moves by step.
//               step values above MAX_VAL are clamped to MAX_VAL.
//               step=0 holds the count, like en=0.
//   undefined : there is no step port and the step is fixed at 1.
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MAX_VAL  highest count value, 1 <= MAX_VAL <= 2**WIDTH-1
//   SATURATE 0 = wrap, 1 = saturate
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   en        count enable
//   up_down   direction, 1 = up, 0 = down
//   load      synchronous parallel load strobe
//   load_val  value to load; clamped to MAX_VAL
//   step      step size (only when UPDOWN_CNT_STEP_EN is defined)
//   count     current count, registered
//   tc        terminal count for the current direction, combinational
//   ovf       registered one-cycle pulse after an up-boundary event
//   unf       registered one-cycle pulse after a down-boundary event
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_CNT_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    // MAX_VAL in the counter width, and again with one extra bit. The extra
    // bit lets range checks see the carry out of count+step.
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);

    // The modulus MAX_VAL+1, reduced to WIDTH bits. It becomes 0 when the
    // range spans the full width. The wrap arithmetic below is modulo
    // 2**WIDTH, and every true result lies in 0..MAX_VAL, so truncating the
    // modulus this way is exact.
    localparam logic [WIDTH-1:0] MOD_W   = WIDTH'(MAX_VAL + 1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic [WIDTH-1:0] step_w;     // effective step, already clamped to MAX_VAL
    logic [WIDTH:0]   sum_ext;    // count + step with the carry kept
    logic [WIDTH-1:0] load_w;     // load value clamped to MAX_VAL
    logic             step_zero;

    // Effective step size
`ifdef UPDOWN_CNT_STEP_EN
    assign step_w = ({1'b0, step} > MAX_EXT) ? MAX_W : step;
`else
    assign step_w = WIDTH'(1);
`endif

    assign step_zero = (step_w == '0);
    assign sum_ext   = {1'b0, count_reg} + {1'b0, step_w};
    assign load_w    = ({1'b0, load_val} > MAX_EXT) ? MAX_W : load_val;

    // Next-state logic
    always_comb begin
        count_next = count_reg;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;

        if (load) begin
            count_next = load_w;
        end else if (en && !step_zero) begin
            if (up_down) begin
                if (sum_ext > MAX_EXT) begin
                    ovf_next   = 1'b1;
                    count_next = SATURATE ? MAX_W : (count_reg + step_w - MOD_W);
                end else begin
                    count_next = count_reg + step_w;
                end
            end else begin
                if (count_reg < step_w) begin
                    unf_next   = 1'b1;
                    count_next = SATURATE ? '0 : (count_reg + MOD_W - step_w);
                end else begin
                    count_next = count_reg - step_w;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

    // Terminal count follows the live direction input, so a reversal shows
    // up in the same cycle.
    assign tc = (up_down && (count_reg == MAX_W)) || (!up_down && (count_reg == '0));

endmodule
